pong_collision_engine: RTL
==========================

Name: pong_collision_engine

Overview:
Clocked, parametrised collision and scoring engine for the Pong playfield. Once per ball step it checks the ball against both paddles and the top/bottom walls, and reports bounces and points to the ball mover. It keeps both player scores and runs the serve/play/game-over sequence. It sits between the ball/paddle movement blocks and the score display.

Parameters:
SCREEN_W, 64, playfield columns; the X coordinate width is clog2(SCREEN_W).
SCREEN_H, 64, playfield rows; the Y coordinate width is clog2(SCREEN_H).
PADDLE_H, 6, paddle height in rows; the paddle occupies rows p_y to p_y+PADDLE_H-1.
P1_COL, 1, column of the left paddle.
P2_COL, 62, column of the right paddle.
SCORE_W, 4, width of each score counter.
WIN_SCORE, 9, score that ends the game; must be < 2**SCORE_W.
SERVE_DELAY, 60, cycles spent in SERVE before serve_req pulses.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ball_x  in  XW  ball column
ball_y  in  YW  ball row
ball_dx  in  1  1 = moving right, 0 = moving left
ball_dy  in  1  1 = moving down, 0 = moving up
p1_y  in  YW  top row of the left paddle
p2_y  in  YW  top row of the right paddle
step_valid  in  1  one-cycle strobe: ball position has just updated
new_game  in  1  one-cycle strobe: clear scores and start a serve
bounce_x  out  1  pulse: paddle hit, reverse X direction
bounce_y  out  1  pulse: wall hit, reverse Y direction
point_p1  out  1  pulse: player 1 scored
point_p2  out  1  pulse: player 2 scored
score1  out  SCORE_W  player 1 score
score2  out  SCORE_W  player 2 score
serve_req  out  1  pulse: recentre the ball and launch it
game_over  out  1  level, high while in GAME_OVER
winner  out  1  0 = player 1, 1 = player 2; valid while game_over is high
state  out  3  current FSM state, for the display

Behaviour:
- Reset: all pulses 0, score1 = score2 = 0, game_over = 0, winner = 0, serve counter = 0, state = IDLE.
- FSM states: IDLE, SERVE, PLAY, POINT, GAME_OVER.
  - IDLE -> SERVE on new_game.
  - SERVE counts SERVE_DELAY cycles. On the last count, serve_req pulses for one cycle and the FSM moves to PLAY.
  - PLAY -> POINT on a scoring step.
  - POINT lasts one cycle. It goes to GAME_OVER if the updated score equals WIN_SCORE, otherwise to SERVE (counter cleared).
  - GAME_OVER holds until new_game.
- new_game in any state: scores cleared, winner cleared, counter cleared, next state SERVE. It has priority over every other event that cycle.
- step_valid is evaluated only in PLAY and ignored in every other state. All outputs are registered: results appear exactly 1 cycle after the step_valid cycle and pulse for exactly 1 cycle.
- Paddle range check: ball_y >= p_y and ball_y <= p_y+PADDLE_H-1.
  - The sum is computed at YW+1 bits so there is no wrap when a paddle touches the bottom edge.
  - A paddle partly off-screen still matches only its on-screen rows.
- Left edge, when ball_dx = 0 and ball_x == P1_COL+1:
  - in range -> bounce_x;
  - out of range -> point_p2 and score2 + 1.
- Right edge, when ball_dx = 1 and ball_x == P2_COL-1: mirror of the left edge, with point_p1 and score1.
- Paddle checks only fire in the direction of travel. A ball moving away from a paddle never bounces.
- Walls:
  - ball_dy = 0 and ball_y == 0 -> bounce_y;
  - ball_dy = 1 and ball_y == SCREEN_H-1 -> bounce_y.
- Simultaneous events:
  - Paddle hit + wall hit (corner): bounce_x and bounce_y in the same cycle.
  - Miss + wall: only the point is raised; bounce_y is suppressed.
- Scores saturate at WIN_SCORE and never wrap. winner latches the side that scored on entry to GAME_OVER.
- Reset asserted mid-game returns everything to IDLE immediately; no pulse is emitted after reset is released.

Optional Feature:
PONG_SPIN_EN
- Defined: adds output hit_zone[1:0], registered alongside bounce_x:
  - 01 = top third of the paddle;
  - 10 = middle;
  - 11 = bottom third;
  - boundaries are floor(PADDLE_H/3) and floor(2*PADDLE_H/3) rows from the paddle top.
  The ball mover uses it to change vertical speed. hit_zone is 00 when there is no hit.
- Undefined: the port is absent and there is no zone logic. All other behaviour is identical.

Decomposition:
- pong_pkg holds:
  - the FSM state enum (3-bit encoding above);
  - DIR_LEFT/DIR_RIGHT and DIR_UP/DIR_DOWN constants;
  - the hit_zone encodings.
- Sub-module pong_paddle_hit: combinational range/zone check, parametrised by YW and PADDLE_H. It is instantiated once per paddle.

Test Plan:
- Reset, then new_game, then wait SERVE_DELAY = 60 cycles -> serve_req pulses on cycle 60 and state = PLAY.
- p1_y = 10, ball (2,12), dx = 0, step_valid -> bounce_x = 1 the next cycle, no point, scores unchanged.
- p1_y = 10, ball (2,16), dx = 0 -> point_p2 and score2 = 1; POINT for one cycle, then SERVE.
- Ball (61,0), dx = 1, dy = 0, p2_y = 0 -> bounce_x and bounce_y in the same cycle. Repeat with p2_y = 20 -> point_p1 only, bounce_y = 0.
- p2_y = 60, ball (61,63), dx = 1, dy = 1 -> bounce_x, with no wrap in the range compare; ball (61,59) -> point_p1.
- Drive score2 to 8, then one more miss -> score2 = 9, game_over = 1, winner = 1; further step_valid is ignored. new_game -> scores 0, state = SERVE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong types: FSM state encoding, ball direction constants and paddle hit-zone codes.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam logic [1:0] ZONE_NONE = 2'b00;
  localparam logic [1:0] ZONE_TOP  = 2'b01;
  localparam logic [1:0] ZONE_MID  = 2'b10;
  localparam logic [1:0] ZONE_BOT  = 2'b11;

endpackage

// File: rtl/pong_paddle_hit.sv
// Combinational paddle row-range check (zero latency, no backpressure); with PONG_SPIN_EN
// it also reports which third of the paddle the ball touched.
module pong_paddle_hit
  import pong_pkg::*;
#(
  parameter int YW       = 6,
  parameter int PADDLE_H = 6
) (
  input  logic [YW-1:0] ball_y_i,
  input  logic [YW-1:0] pad_y_i,
  output logic          hit_o
`ifdef PONG_SPIN_EN
  ,
  output logic [1:0]    zone_o
`endif
);

  // One extra bit so a paddle hanging past the bottom edge does not wrap to row 0.
  logic [YW:0] pad_bot;

  assign pad_bot = {1'b0, pad_y_i} + (YW+1)'(PADDLE_H - 1);
  assign hit_o   = (ball_y_i >= pad_y_i) && ({1'b0, ball_y_i} <= pad_bot);

`ifdef PONG_SPIN_EN
  localparam logic [YW-1:0] B_MID = YW'(PADDLE_H / 3);
  localparam logic [YW-1:0] B_BOT = YW'((2 * PADDLE_H) / 3);

  logic [YW-1:0] off;

  assign off = ball_y_i - pad_y_i;

  always_comb begin
    zone_o = ZONE_NONE;
    if (hit_o) begin
      if (off < B_MID)      zone_o = ZONE_TOP;
      else if (off < B_BOT) zone_o = ZONE_MID;
      else                  zone_o = ZONE_BOT;
    end
  end
`endif

endmodule

// File: rtl/pong_collision_engine.sv
// Pong collision/scoring engine with serve/play/game-over FSM; results registered 1 cycle after step_valid,
// no backpressure. Optional PONG_SPIN_EN adds the hit_zone output.
module pong_collision_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = 64,
  parameter int SCREEN_H    = 64,
  parameter int PADDLE_H    = 6,
  parameter int P1_COL      = 1,
  parameter int P2_COL      = 62,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(SCREEN_W)-1:0] ball_x,
  input  logic [$clog2(SCREEN_H)-1:0] ball_y,
  input  logic                        ball_dx,
  input  logic                        ball_dy,
  input  logic [$clog2(SCREEN_H)-1:0] p1_y,
  input  logic [$clog2(SCREEN_H)-1:0] p2_y,
  input  logic                        step_valid,
  input  logic                        new_game,
  output logic                        bounce_x,
  output logic                        bounce_y,
  output logic                        point_p1,
  output logic                        point_p2,
  output logic [SCORE_W-1:0]          score1,
  output logic [SCORE_W-1:0]          score2,
  output logic                        serve_req,
  output logic                        game_over,
  output logic                        winner,
  output logic [2:0]                  state
`ifdef PONG_SPIN_EN
  ,
  output logic [1:0]                  hit_zone
`endif
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic [XW-1:0]      L_EDGE   = XW'(P1_COL + 1);
  localparam logic [XW-1:0]      R_EDGE   = XW'(P2_COL - 1);
  localparam logic [YW-1:0]      Y_BOT    = YW'(SCREEN_H - 1);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CW-1:0]      CNT_LAST = CW'(SERVE_DELAY - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic               winner_q, winner_d;
  logic               scorer_q, scorer_d;
  logic               bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
  logic               point_p1_q, point_p1_d, point_p2_q, point_p2_d;
  logic               serve_req_q, serve_req_d;

  logic p1_hit, p2_hit;
  logic at_left, at_right, wall;
  logic hit_l, hit_r, miss_l, miss_r;

`ifdef PONG_SPIN_EN
  logic [1:0] p1_zone, p2_zone;
  logic [1:0] zone_q, zone_d;
`endif

  pong_paddle_hit #(.YW(YW), .PADDLE_H(PADDLE_H)) u_p1_hit (
    .ball_y_i (ball_y),
    .pad_y_i  (p1_y),
    .hit_o    (p1_hit)
`ifdef PONG_SPIN_EN
    ,
    .zone_o   (p1_zone)
`endif
  );

  pong_paddle_hit #(.YW(YW), .PADDLE_H(PADDLE_H)) u_p2_hit (
    .ball_y_i (ball_y),
    .pad_y_i  (p2_y),
    .hit_o    (p2_hit)
`ifdef PONG_SPIN_EN
    ,
    .zone_o   (p2_zone)
`endif
  );

  // Paddle columns are only checked in the direction of travel.
  assign at_left  = (ball_dx == DIR_LEFT)  && (ball_x == L_EDGE);
  assign at_right = (ball_dx == DIR_RIGHT) && (ball_x == R_EDGE);
  assign wall     = ((ball_dy == DIR_UP)   && (ball_y == '0)) ||
                    ((ball_dy == DIR_DOWN) && (ball_y == Y_BOT));
  assign hit_l    = at_left  &&  p1_hit;
  assign hit_r    = at_right &&  p2_hit;
  assign miss_l   = at_left  && !p1_hit;
  assign miss_r   = at_right && !p2_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    scorer_d    = scorer_q;
    bounce_x_d  = 1'b0;
    bounce_y_d  = 1'b0;
    point_p1_d  = 1'b0;
    point_p2_d  = 1'b0;
    serve_req_d = 1'b0;
`ifdef PONG_SPIN_EN
    zone_d      = ZONE_NONE;
`endif
    if (new_game) begin
      state_d  = ST_SERVE;
      cnt_d    = '0;
      score1_d = '0;
      score2_d = '0;
      winner_d = 1'b0;
    end else begin
      case (state_q)
        ST_SERVE: begin
          if (cnt_q == CNT_LAST) begin
            serve_req_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PLAY: begin
          if (step_valid) begin
            // A miss wins over any simultaneous wall bounce.
            if (miss_l) begin
              point_p2_d = 1'b1;
              scorer_d   = 1'b1;
              state_d    = ST_POINT;
              if (score2_q != WIN) score2_d = score2_q + 1'b1;
            end else if (miss_r) begin
              point_p1_d = 1'b1;
              scorer_d   = 1'b0;
              state_d    = ST_POINT;
              if (score1_q != WIN) score1_d = score1_q + 1'b1;
            end else begin
              bounce_x_d = hit_l || hit_r;
              bounce_y_d = wall;
`ifdef PONG_SPIN_EN
              if (hit_l)      zone_d = p1_zone;
              else if (hit_r) zone_d = p2_zone;
`endif
            end
          end
        end
        ST_POINT: begin
          if ((scorer_q ? score2_q : score1_q) == WIN) begin
            state_d  = ST_GAME_OVER;
            winner_d = scorer_q;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = '0;
          end
        end
        ST_IDLE, ST_GAME_OVER: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= 1'b0;
      scorer_q    <= 1'b0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
      point_p1_q  <= 1'b0;
      point_p2_q  <= 1'b0;
      serve_req_q <= 1'b0;
`ifdef PONG_SPIN_EN
      zone_q      <= ZONE_NONE;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      scorer_q    <= scorer_d;
      bounce_x_q  <= bounce_x_d;
      bounce_y_q  <= bounce_y_d;
      point_p1_q  <= point_p1_d;
      point_p2_q  <= point_p2_d;
      serve_req_q <= serve_req_d;
`ifdef PONG_SPIN_EN
      zone_q      <= zone_d;
`endif
    end
  end

  assign bounce_x  = bounce_x_q;
  assign bounce_y  = bounce_y_q;
  assign point_p1  = point_p1_q;
  assign point_p2  = point_p2_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign serve_req = serve_req_q;
  assign game_over = (state_q == ST_GAME_OVER);
  assign winner    = winner_q;
  assign state     = state_q;
`ifdef PONG_SPIN_EN
  assign hit_zone  = zone_q;
`endif

endmodule
